// File: rtl/pipearch_c0_arbiter_pkg.sv
// Shared CCI-P c0 types and mdata tag helpers for the c0 read-channel arbiter.
package pipearch_c0_arbiter_pkg;

  localparam int PIPEARCH_C0_ARB_MAX_CLIENTS = 8;
  localparam int C0_ARB_TAG_MAX_W            = 3;

  localparam logic [3:0] eREQ_RDLINE_I = 4'h0;
  localparam logic [3:0] eRSP_RDLINE   = 4'h0;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  rsvd1;
    t_ccip_clLen cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_cci_c0_ReqMemHdr;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_cci_c0_RspMemHdr;

  typedef struct packed {
    t_cci_c0_ReqMemHdr hdr;
    logic              valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_cci_c0_RspMemHdr hdr;
    logic [511:0]      data;
    logic              rspValid;
    logic              mmioRdValid;
    logic              mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef t_cci_c0_ReqMemHdr t_c0_arb_qentry;

  function automatic logic cci_c0Rx_isReadRsp(input t_if_ccip_c0_Rx rx);
    return rx.rspValid && (rx.hdr.resp_type == eRSP_RDLINE);
  endfunction

  // Tag occupies the top `bits` bits of mdata.
  function automatic logic [15:0] c0_arb_set_tag(input logic [15:0] mdata,
                                                  input logic [C0_ARB_TAG_MAX_W-1:0] tag,
                                                  input int unsigned bits);
    logic [15:0] mask;
    mask = ~(16'hFFFF >> bits);
    return (mdata & ~mask) | ((16'(tag) << (16 - bits)) & mask);
  endfunction

  function automatic logic [C0_ARB_TAG_MAX_W-1:0] c0_arb_get_tag(input logic [15:0] mdata,
                                                                 input int unsigned bits);
    return C0_ARB_TAG_MAX_W'(mdata >> (16 - bits));
  endfunction

  function automatic logic [2:0] c0_arb_cl_lines(input t_ccip_clLen len);
    case (len)
      eCL_LEN_2: return 3'd2;
      eCL_LEN_4: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/pipearch_c0_req_queue.sv
// Per-client register FIFO with combinational head; accepts a push when full if a pop happens in the same cycle.
module pipearch_c0_req_queue
  import pipearch_c0_arbiter_pkg::*;
#(
  parameter int LOG2_QDEPTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  t_c0_arb_qentry       push_data_i,
  input  logic                 pop_i,
  output t_c0_arb_qentry       head_o,
  output logic [LOG2_QDEPTH:0] count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int DEPTH = 1 << LOG2_QDEPTH;

  t_c0_arb_qentry             mem_q [DEPTH];
  logic [LOG2_QDEPTH-1:0]     rd_ptr_q, wr_ptr_q;
  logic [LOG2_QDEPTH:0]       count_q, count_d;
  logic                       do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (LOG2_QDEPTH+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pipearch_c0_arbiter.sv
// Round-robin sharing of one CCI-P c0 read channel; responses steered back by an mdata tag.
// Optional counters: define PIPEARCH_C0_ARB_STATS_EN to add stat_lines/stat_stall.
module pipearch_c0_arbiter
  import pipearch_c0_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int CLIENT_ID_BITS = $clog2(NUM_CLIENTS),
  parameter int LOG2_QDEPTH    = 3,
  parameter int ALMFULL_SLACK  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              c0TxAlmFull,
  input  t_if_ccip_c0_Rx                    cp2af_sRx_c0,
  output t_if_ccip_c0_Tx                    af2cp_sTx_c0,
  output logic [NUM_CLIENTS-1:0]            cl_c0TxAlmFull,
  output t_if_ccip_c0_Rx [NUM_CLIENTS-1:0]  cl_sRx_c0,
  input  t_if_ccip_c0_Tx [NUM_CLIENTS-1:0]  cl_sTx_c0,
  output logic                              overflow_err
`ifdef PIPEARCH_C0_ARB_STATS_EN
  ,
  output logic [NUM_CLIENTS-1:0][31:0]      stat_lines,
  output logic [31:0]                       stat_stall
`endif
);

  localparam int QDEPTH = 1 << LOG2_QDEPTH;
  localparam int CW     = LOG2_QDEPTH + 1;

  logic [NUM_CLIENTS-1:0]      q_push, q_pop, q_full, q_empty, almfull_d, almfull_q;
  t_c0_arb_qentry              q_head  [NUM_CLIENTS];
  logic [CW-1:0]               q_count [NUM_CLIENTS];

  logic                        win_vld;
  logic [CLIENT_ID_BITS-1:0]   win_idx, rr_ptr_q, rr_ptr_d;
  logic                        tx_vld_q;
  t_cci_c0_ReqMemHdr           tx_hdr_q, tx_hdr_d;
  logic                        overflow_q;

  logic [C0_ARB_TAG_MAX_W-1:0] rsp_tag;
  logic [NUM_CLIENTS-1:0]      rx_vld_d, rx_vld_q;
  t_cci_c0_RspMemHdr           rx_hdr_d, rx_hdr_q;
  logic [511:0]                rx_data_q;
  logic                        unused_rx;

  assign rsp_tag   = c0_arb_get_tag(cp2af_sRx_c0.hdr.mdata, CLIENT_ID_BITS);
  assign unused_rx = cp2af_sRx_c0.mmioRdValid ^ cp2af_sRx_c0.mmioWrValid;

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
    assign q_push[gi]    = cl_sTx_c0[gi].valid;
    assign q_pop[gi]     = win_vld && (win_idx == CLIENT_ID_BITS'(gi));
    assign almfull_d[gi] = (q_count[gi] >= CW'(QDEPTH - ALMFULL_SLACK));
    assign rx_vld_d[gi]  = cci_c0Rx_isReadRsp(cp2af_sRx_c0) && (rsp_tag == C0_ARB_TAG_MAX_W'(gi));

    pipearch_c0_req_queue #(.LOG2_QDEPTH(LOG2_QDEPTH)) u_q (
      .clk         (clk),
      .reset       (reset),
      .push_i      (q_push[gi]),
      .push_data_i (cl_sTx_c0[gi].hdr),
      .pop_i       (q_pop[gi]),
      .head_o      (q_head[gi]),
      .count_o     (q_count[gi]),
      .full_o      (q_full[gi]),
      .empty_o     (q_empty[gi])
    );
  end

  // Round-robin search starts one past the last winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      int cand;
      cand = (int'(rr_ptr_q) + k) % NUM_CLIENTS;
      if (!win_vld && !q_empty[cand]) begin
        win_vld = 1'b1;
        win_idx = CLIENT_ID_BITS'(cand);
      end
    end
    if (c0TxAlmFull) win_vld = 1'b0;
    rr_ptr_d = win_vld ? win_idx : rr_ptr_q;
  end

  always_comb begin
    tx_hdr_d = '0;
    if (win_vld) begin
      tx_hdr_d       = q_head[win_idx];
      tx_hdr_d.mdata = c0_arb_set_tag(q_head[win_idx].mdata, C0_ARB_TAG_MAX_W'(win_idx), CLIENT_ID_BITS);
    end
    rx_hdr_d       = cp2af_sRx_c0.hdr;
    rx_hdr_d.mdata = c0_arb_set_tag(cp2af_sRx_c0.hdr.mdata, '0, CLIENT_ID_BITS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= CLIENT_ID_BITS'(NUM_CLIENTS - 1);
      tx_vld_q   <= 1'b0;
      tx_hdr_q   <= '0;
      rx_vld_q   <= '0;
      almfull_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tx_vld_q   <= win_vld;
      tx_hdr_q   <= tx_hdr_d;
      rx_vld_q   <= rx_vld_d;
      almfull_q  <= almfull_d;
      overflow_q <= overflow_q || |(q_push & q_full & ~q_pop);
    end
  end

  always_ff @(posedge clk) begin
    rx_hdr_q  <= rx_hdr_d;
    rx_data_q <= cp2af_sRx_c0.data;
  end

  assign cl_c0TxAlmFull = almfull_q;
  assign overflow_err   = overflow_q;

  always_comb begin
    af2cp_sTx_c0.valid = tx_vld_q;
    af2cp_sTx_c0.hdr   = tx_hdr_q;
  end

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cl_sRx_c0[i].hdr         = rx_hdr_q;
      cl_sRx_c0[i].data        = rx_data_q;
      cl_sRx_c0[i].rspValid    = rx_vld_q[i];
      cl_sRx_c0[i].mmioRdValid = 1'b0;
      cl_sRx_c0[i].mmioWrValid = 1'b0;
    end
  end

`ifdef PIPEARCH_C0_ARB_STATS_EN
  logic [NUM_CLIENTS-1:0][31:0] stat_lines_q;
  logic [31:0]                  stat_stall_q;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lines_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (win_vld)
        stat_lines_q[win_idx] <= sat_add32(stat_lines_q[win_idx], 32'(c0_arb_cl_lines(q_head[win_idx].cl_len)));
      if (c0TxAlmFull && !(&q_empty))
        stat_stall_q <= sat_add32(stat_stall_q, 32'd1);
    end
  end

  assign stat_lines = stat_lines_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_pipearch_c0_arbiter.sv
// Directed self-checking bench for pipearch_c0_arbiter (NUM_CLIENTS=4, depth 8, slack 4).
module tb_pipearch_c0_arbiter;
  import pipearch_c0_arbiter_pkg::*;

  localparam int NC = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     c0TxAlmFull;
  t_if_ccip_c0_Rx           cp2af_sRx_c0;
  t_if_ccip_c0_Tx           af2cp_sTx_c0;
  logic [NC-1:0]            cl_c0TxAlmFull;
  t_if_ccip_c0_Rx [NC-1:0]  cl_sRx_c0;
  t_if_ccip_c0_Tx [NC-1:0]  cl_sTx_c0;
  logic                     overflow_err;
`ifdef PIPEARCH_C0_ARB_STATS_EN
  logic [NC-1:0][31:0]      stat_lines;
  logic [31:0]              stat_stall;
`endif

  always #5 clk = ~clk;

  pipearch_c0_arbiter #(.NUM_CLIENTS(NC)) dut (
    .clk            (clk),
    .reset          (reset),
    .c0TxAlmFull    (c0TxAlmFull),
    .cp2af_sRx_c0   (cp2af_sRx_c0),
    .af2cp_sTx_c0   (af2cp_sTx_c0),
    .cl_c0TxAlmFull (cl_c0TxAlmFull),
    .cl_sRx_c0      (cl_sRx_c0),
    .cl_sTx_c0      (cl_sTx_c0),
    .overflow_err   (overflow_err)
`ifdef PIPEARCH_C0_ARB_STATS_EN
    ,
    .stat_lines     (stat_lines),
    .stat_stall     (stat_stall)
`endif
  );

  typedef struct {
    logic [15:0] mdata;
    logic [41:0] addr;
    int unsigned cyc;
  } t_obs;

  t_obs        glog[$];
  t_obs        obs;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int unsigned drop_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream grant log, sampled mid-cycle.
  always @(negedge clk) begin
    if (af2cp_sTx_c0.valid) begin
      obs.mdata = af2cp_sTx_c0.hdr.mdata;
      obs.addr  = af2cp_sTx_c0.hdr.address;
      obs.cyc   = cyc;
      glog.push_back(obs);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int k, input logic [15:0] exp_mdata);
    if (k < glog.size()) chk($sformatf("%s_md%0d", tag, k), 64'(glog[k].mdata), 64'(exp_mdata));
    else chk($sformatf("%s_missing%0d", tag, k), 64'(glog.size()), 64'(k + 1));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  function automatic t_if_ccip_c0_Tx mk_req(input logic [41:0] a, input t_ccip_clLen l, input logic [15:0] m);
    t_if_ccip_c0_Tx t;
    t = '0;
    t.valid       = 1'b1;
    t.hdr.address = a;
    t.hdr.cl_len  = l;
    t.hdr.mdata   = m;
    return t;
  endfunction

  task automatic send_rsp(input logic [15:0] m, input logic [3:0] rtype, input logic [63:0] d);
    cp2af_sRx_c0                = '0;
    cp2af_sRx_c0.rspValid       = 1'b1;
    cp2af_sRx_c0.hdr.resp_type  = rtype;
    cp2af_sRx_c0.hdr.mdata      = m;
    cp2af_sRx_c0.data           = 512'(d);
    tick(1);
    cp2af_sRx_c0 = '0;
  endtask

  initial begin
    reset        = 1'b1;
    c0TxAlmFull  = 1'b0;
    cp2af_sRx_c0 = '0;
    cl_sTx_c0    = '0;
    tick(2);
    reset = 1'b0;

    // Reset state
    chk("rst_txvalid", 64'(af2cp_sTx_c0.valid), 64'd0);
    chk("rst_txhdr", 64'(af2cp_sTx_c0.hdr), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
    chk("rst_almfull", 64'(cl_c0TxAlmFull), 64'd0);
    for (int i = 0; i < NC; i++) chk($sformatf("rst_rspv%0d", i), 64'(cl_sRx_c0[i].rspValid), 64'd0);

    // Single client request and tagged response
    cl_sTx_c0[1] = mk_req(42'h100, eCL_LEN_4, 16'h0005);
    tick(1);
    cl_sTx_c0 = '0;
    chk("single_lat0", 64'(af2cp_sTx_c0.valid), 64'd0);
    tick(1);
    chk("single_valid", 64'(af2cp_sTx_c0.valid), 64'd1);
    chk("single_mdata", 64'(af2cp_sTx_c0.hdr.mdata), 64'h4005);
    chk("single_addr", 64'(af2cp_sTx_c0.hdr.address), 64'h100);
    chk("single_len", 64'(af2cp_sTx_c0.hdr.cl_len), 64'(eCL_LEN_4));
    tick(1);
    chk("idle_valid", 64'(af2cp_sTx_c0.valid), 64'd0);
    chk("idle_hdr", 64'(af2cp_sTx_c0.hdr), 64'd0);
    send_rsp(16'h4005, eRSP_RDLINE, 64'hCAFE_0001);
    chk("rsp_v1", 64'(cl_sRx_c0[1].rspValid), 64'd1);
    chk("rsp_md1", 64'(cl_sRx_c0[1].hdr.mdata), 64'h0005);
    chk("rsp_data1", cl_sRx_c0[1].data[63:0], 64'hCAFE_0001);
    chk("rsp_v0", 64'(cl_sRx_c0[0].rspValid), 64'd0);
    chk("rsp_v2", 64'(cl_sRx_c0[2].rspValid), 64'd0);
    chk("rsp_v3", 64'(cl_sRx_c0[3].rspValid), 64'd0);
    chk("rsp_mmio1", 64'({cl_sRx_c0[1].mmioRdValid, cl_sRx_c0[1].mmioWrValid}), 64'd0);
    send_rsp(16'h4005, 4'h1, 64'h0);
    chk("wrrsp_v1", 64'(cl_sRx_c0[1].rspValid), 64'd0);

    // Fairness: 4 clients x 3 requests
    do_reset();
    glog.delete();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < NC; c++) cl_sTx_c0[c] = mk_req(42'(c * 64 + p), eCL_LEN_1, 16'(c * 16 + p));
      tick(1);
    end
    cl_sTx_c0 = '0;
    tick(14);
    chk("fair_count", 64'(glog.size()), 64'd12);
    for (int k = 0; k < 12; k++) begin
      chk_log("fair", k, 16'(((k % NC) << 14) | ((k % NC) * 16 + k / NC)));
      if (k > 0 && k < glog.size())
        chk($sformatf("fair_cyc%0d", k), 64'(glog[k].cyc - glog[0].cyc), 64'(k));
    end

    // Backpressure: upstream almFull held while client 2 fills to its threshold
    glog.delete();
    c0TxAlmFull = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cl_sTx_c0[2] = mk_req(42'h200 + 42'(n), eCL_LEN_1, 16'(n));
      tick(1);
    end
    cl_sTx_c0 = '0;
    chk("bp_almfull_lag", 64'(cl_c0TxAlmFull[2]), 64'd0);
    tick(1);
    chk("bp_almfull", 64'(cl_c0TxAlmFull), 64'b0100);
    tick(15);
    chk("bp_nogrant", 64'(glog.size()), 64'd0);
    chk("bp_ovf", 64'(overflow_err), 64'd0);
    c0TxAlmFull = 1'b0;
    drop_cyc = cyc;
    tick(8);
    chk("bp_count", 64'(glog.size()), 64'd4);
    if (glog.size() > 0) chk("bp_resume", 64'(glog[0].cyc), 64'(drop_cyc + 1));
    for (int k = 0; k < 4; k++) chk_log("bp", k, 16'h8000 | 16'(k));
    chk("bp_almfull_clr", 64'(cl_c0TxAlmFull[2]), 64'd0);

    // Overflow: 9 pushes into client 0 while stalled
    do_reset();
    glog.delete();
    c0TxAlmFull = 1'b1;
    for (int n = 0; n < 8; n++) begin
      cl_sTx_c0[0] = mk_req(42'h300 + 42'(n), eCL_LEN_1, 16'(n));
      tick(1);
    end
    chk("ovf_before", 64'(overflow_err), 64'd0);
    cl_sTx_c0[0] = mk_req(42'h308, eCL_LEN_1, 16'd8);
    tick(1);
    cl_sTx_c0 = '0;
    chk("ovf_set", 64'(overflow_err), 64'd1);
    chk("ovf_almfull0", 64'(cl_c0TxAlmFull[0]), 64'd1);
    c0TxAlmFull = 1'b0;
    tick(12);
    chk("ovf_held", 64'(overflow_err), 64'd1);
    chk("ovf_count", 64'(glog.size()), 64'd8);
    for (int k = 0; k < 8; k++) chk_log("ovf", k, 16'(k));

    // Push into a full queue in the same cycle as its pop
    do_reset();
    chk("pp_ovf_rst", 64'(overflow_err), 64'd0);
    glog.delete();
    c0TxAlmFull = 1'b1;
    for (int n = 0; n < 8; n++) begin
      cl_sTx_c0[0] = mk_req(42'h400 + 42'(n), eCL_LEN_1, 16'h10 + 16'(n));
      tick(1);
    end
    c0TxAlmFull  = 1'b0;
    cl_sTx_c0[0] = mk_req(42'h408, eCL_LEN_1, 16'h18);
    tick(1);
    cl_sTx_c0 = '0;
    tick(12);
    chk("pp_ovf", 64'(overflow_err), 64'd0);
    chk("pp_count", 64'(glog.size()), 64'd9);
    for (int k = 0; k < 9; k++) chk_log("pp", k, 16'h10 + 16'(k));

    // Reset with queued requests, then a late response tagged client 3
    c0TxAlmFull = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cl_sTx_c0[1] = mk_req(42'h500 + 42'(n), eCL_LEN_1, 16'(n));
      tick(1);
    end
    cl_sTx_c0 = '0;
    glog.delete();
    do_reset();
    c0TxAlmFull = 1'b0;
    tick(10);
    chk("rstmid_nogrant", 64'(glog.size()), 64'd0);
    chk("rstmid_almfull", 64'(cl_c0TxAlmFull), 64'd0);
    send_rsp(16'hC0AB, eRSP_RDLINE, 64'h1234_5678);
    chk("rstmid_rspv3", 64'(cl_sRx_c0[3].rspValid), 64'd1);
    chk("rstmid_md3", 64'(cl_sRx_c0[3].hdr.mdata), 64'h00AB);
    chk("rstmid_rspv1", 64'(cl_sRx_c0[1].rspValid), 64'd0);

`ifdef PIPEARCH_C0_ARB_STATS_EN
    do_reset();
    cl_sTx_c0[0] = mk_req(42'h600, eCL_LEN_4, 16'd0);
    tick(1);
    cl_sTx_c0[0] = mk_req(42'h604, eCL_LEN_2, 16'd1);
    tick(1);
    cl_sTx_c0[0] = mk_req(42'h606, eCL_LEN_1, 16'd2);
    tick(1);
    cl_sTx_c0 = '0;
    tick(5);
    chk("stat_lines0", 64'(stat_lines[0]), 64'd7);
    chk("stat_stall", 64'(stat_stall), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
